// File: rtl/deser_pkg.sv
// Shared constants for the serial deserializer.
// Output-side FSM encodings and default counter width.
package deser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/deser_out_reg.sv
// Output word holding register with valid/ready handshake.
// Generates the sticky overrun flag when a completed word is dropped.
module deser_out_reg
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_i,
    input  logic [WIDTH-1:0] cand_i,
    input  logic             word_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);

    logic             state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ovr_q, ovr_d;
    logic             take;
    logic             drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ovr_d   = ovr_q;
        take    = (state_q == ST_EMPTY) || word_ready;
        drop    = load_i && !take && !clear;
        if (clear) begin
            state_d = ST_EMPTY;
            word_d  = '0;
        end else begin
            if (state_q == ST_FULL && word_ready) begin
                state_d = ST_EMPTY;
            end
            if (load_i && take) begin
                state_d = ST_FULL;
                word_d  = cand_i;
            end
        end
        // A drop in the same cycle outranks the clear request.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == ST_FULL);
    assign overrun    = ovr_q;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with valid/ready output.
// Shift register and bit counter live here; output side is a sub-module.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             complete;

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (bit_valid) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[WIDTH-2:0], bit_in};
            end else begin
                shift_d = {bit_in, shift_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
                complete = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .load_i      (complete),
        .cand_i      (shift_d),
        .word_ready  (word_ready),
        .overrun_clr (overrun_clr),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .overrun     (overrun)
    );

    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: both bit orders against a bit-list model.
// Directed steps followed by a randomized phase.
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic         clear;
    logic         word_ready;
    logic         overrun_clr;
    logic [W-1:0] wo0, wo1;
    logic         wv0, wv1;
    logic [2:0]   bc0, bc1;
    logic         ov0, ov1;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          mq[$];
    logic        m_valid;
    logic        m_ovr;
    logic [W-1:0] m_w0, m_w1;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .word_out(wo0), .word_valid(wv0),
        .word_ready(word_ready), .bit_cnt(bc0), .overrun(ov0),
        .overrun_clr(overrun_clr)
    );

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .word_out(wo1), .word_valid(wv1),
        .word_ready(word_ready), .bit_cnt(bc1), .overrun(ov1),
        .overrun_clr(overrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] a, b;
        logic         set;
        set = 1'b0;
        if (!rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_w0    = '0;
            m_w1    = '0;
            m_ovr   = 1'b0;
        end else begin
            if (m_valid && word_ready) m_valid = 1'b0;
            if (clear) begin
                mq.delete();
                m_valid = 1'b0;
                m_w0    = '0;
                m_w1    = '0;
            end else if (bit_valid) begin
                mq.push_back(bit_in);
                if (mq.size() == W) begin
                    a = '0;
                    b = '0;
                    for (int i = 0; i < W; i++) begin
                        a = a | (W'(mq[i]) << (W - 1 - i));
                        b = b | (W'(mq[i]) << i);
                    end
                    mq.delete();
                    if (!wv0 || word_ready) begin
                        m_w0    = a;
                        m_w1    = b;
                        m_valid = 1'b1;
                    end else begin
                        set = 1'b1;
                    end
                end
            end
            if (set) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    endtask

    task automatic tick();
        logic was_valid;
        @(posedge clk);
        was_valid = m_valid;
        model_edge();
        #1;
        chk("valid0", 32'(wv0), 32'(m_valid));
        chk("valid1", 32'(wv1), 32'(m_valid));
        chk("word0", 32'(wo0), 32'(m_w0));
        chk("word1", 32'(wo1), 32'(m_w1));
        chk("cnt0", 32'(bc0), mq.size());
        chk("cnt1", 32'(bc1), mq.size());
        chk("ovr0", 32'(ov0), 32'(m_ovr));
        chk("ovr1", 32'(ov1), 32'(m_ovr));
    endtask

    task automatic send_bits(input logic [7:0] v, input int from,
                             input int to);
        for (int i = from; i < to; i++) begin
            bit_valid = 1'b1;
            bit_in    = v[7-i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic idle();
        bit_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b0;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        clear       = 1'b0;
        word_ready  = 1'b0;
        overrun_clr = 1'b0;
        m_valid     = 1'b0;
        m_ovr       = 1'b0;
        m_w0        = '0;
        m_w1        = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            bit_in    = 1'($urandom);
            bit_valid = 1'($urandom);
            tick();
        end
        chk("rst_word", 32'(wo0), 0);
        chk("rst_valid", 32'(wv0), 0);
        chk("rst_cnt", 32'(bc0), 0);
        chk("rst_ovr", 32'(ov0), 0);
        rst        = 1'b1;
        word_ready = 1'b1;

        send_bits(8'hA5, 0, 8);
        chk("a5_msb", 32'(wo0), 32'hA5);
        chk("a5_lsb", 32'(wo1), 32'hA5);
        chk("a5_valid", 32'(wv0), 1);
        idle();
        chk("a5_one_cycle", 32'(wv0), 0);

        send_bits(8'hC0, 0, 8);
        chk("c0_lsb", 32'(wo1), 32'h03);
        chk("c0_msb", 32'(wo0), 32'hC0);
        idle();

        word_ready = 1'b0;
        send_bits(8'h3C, 0, 8);
        send_bits(8'hF0, 0, 8);
        chk("ovr_hold", 32'(wo0), 32'h3C);
        chk("ovr_set", 32'(ov0), 1);
        word_ready = 1'b1;
        idle();
        chk("ovr_hs", 32'(wv0), 0);
        overrun_clr = 1'b1;
        idle();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(ov0), 0);

        send_bits(8'hFF, 0, 5);
        clear = 1'b1;
        idle();
        clear = 1'b0;
        chk("clr_cnt", 32'(bc0), 0);
        send_bits(8'h81, 0, 8);
        chk("clr_word", 32'(wo0), 32'h81);
        idle();

        word_ready = 1'b0;
        send_bits(8'h11, 0, 8);
        send_bits(8'h22, 0, 7);
        word_ready = 1'b1;
        send_bits(8'h22, 7, 8);
        chk("b2b_valid", 32'(wv0), 1);
        chk("b2b_word", 32'(wo0), 32'h22);
        chk("b2b_ovr", 32'(ov0), 0);

        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) != 0);
            bit_in      = 1'($urandom);
            bit_valid   = ($urandom_range(0, 3) != 0);
            word_ready  = ($urandom_range(0, 2) == 0);
            clear       = ($urandom_range(0, 39) == 0);
            overrun_clr = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Consumes the registered serial bit stream produced by the team's D flip-flop stage and assembles it into WIDTH-bit parallel words.
- Delivers each word through a valid/ready output register.
- Flags overrun when a new word completes while the previous word has not been taken.
- Sits directly downstream of the single-bit D-FF stage, feeding word-level logic.

Parameters:
- WIDTH, 8, bits per assembled word (legal range 2..32).
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- bit_in  input  1  serial data bit from the D-FF stage.
- bit_valid  input  1  bit_in is accepted on this posedge when high.
- clear  input  1  synchronous flush of the partial word and the output word.
- word_out  output  WIDTH  assembled word; stable while word_valid is high.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer takes the word on a posedge where word_valid && word_ready.
- bit_cnt  output  $clog2(WIDTH)  number of bits held in the partial word (0..WIDTH-1).
- overrun  output  1  sticky flag: a completed word was dropped.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (rst==0 at posedge): shift register=0, bit_cnt=0, word_out=0, word_valid=0, overrun=0. Reset has priority over every other input.
- Accept: on each posedge with bit_valid=1, shift bit_in into the shift register and increment bit_cnt. MSB_FIRST=1 shifts left with the new bit at LSB; MSB_FIRST=0 shifts right with the new bit at MSB.
- Completion: the posedge that accepts a bit while bit_cnt==WIDTH-1 completes the word.
  - bit_cnt wraps to 0.
  - The full word (including that bit) is the candidate.
- Transfer: the candidate loads word_out, and word_valid=1 from the next cycle, if word_valid==0 or (word_valid && word_ready) on that same posedge. Latency is 1 cycle from the last bit to word_valid.
- Back-to-back: with word_ready held high, one word is produced every WIDTH accepted bits with no bubbles.
- Overrun: if completion occurs while word_valid=1 and word_ready=0:
  - The candidate is discarded, and word_out/word_valid are unchanged.
  - overrun=1 from the next cycle.
  - The counter still wraps to 0.
- Handshake: word_valid falls the cycle after a word_ready handshake unless a new completion reloads it on that same posedge, in which case it stays high.
- word_out never changes while word_valid=1 and word_ready=0.
- clear=1: the next state is shift register=0, bit_cnt=0, word_valid=0. A bit_valid or completion in the same cycle is ignored. overrun is unaffected.
- overrun_clr=1: overrun=0 next cycle. If an overrun event occurs in the same cycle, the set wins and overrun=1.
- bit_valid=0: all state holds, except output handshake effects.
- Two-state FSM on the output side: EMPTY (word_valid=0) and FULL (word_valid=1).
  - EMPTY→FULL on completion.
  - FULL→EMPTY on handshake without completion.
  - FULL→FULL on handshake with completion, or on a stall.
  - Any→EMPTY on clear or reset.

Decomposition:
- Package deser_pkg holds the WIDTH-derived constant CNT_W=$clog2(WIDTH) and the localparam encodings of the output FSM states (ST_EMPTY=1'b0, ST_FULL=1'b1).
- One natural sub-module: deser_out_reg, the word holding register with valid/ready, load, and overrun generation. The shift register and counter stay in the top module.

Test Plan:
- rst=0 for 2 cycles with random bit_in/bit_valid → word_out=0x00, word_valid=0, bit_cnt=0, overrun=0.
- WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, word_ready=1 → word_out=0xA5 with word_valid high one cycle after the 8th bit, for exactly 1 cycle.
- MSB_FIRST=0, same bit sequence → word_out=0xA5 bit-reversed=0xA5 (palindrome). Then send 1,1,0,0,0,0,0,0 → word_out=0x03.
- word_ready=0, send 16 bits (0x3C then 0xF0) → word_out stays 0x3C, overrun=1 after the 16th bit. Then word_ready=1 → handshake, word_valid=0. Then overrun_clr=1 → overrun=0.
- Send 5 bits, assert clear, then send 8 bits 0x81 → bit_cnt returns to 0 after clear, and the next word_out=0x81 with no leftover bits.
- word_valid=1 holding 0x11, word_ready=1 on the same posedge that completes 0x22 → word_valid stays high, word_out=0x22 next cycle, overrun=0.
